updown_seq_ctrl: RTL and testbench

- Sequencer for the 4-bit up/down load counter.
- Takes run commands (start value, target value, direction) over a valid/ready handshake.
- Drives the counter's load/control/data_in pins so it loads the start value, steps toward the target, stops exactly on it and holds.
- Sits between the command source and a single counter instance; the counter is external to this block.

---
 rtl/updown_seq_pkg.sv | 16 +
 rtl/updown_seq_ctrl.sv | 116 +++++++++++
 tb/tb_updown_seq_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/updown_seq_pkg.sv
// Shared types and constants for the up/down counter sequencer.
// State encoding, direction values and the default counter width.
package updown_seq_pkg;

    localparam int   DEFAULT_WIDTH = 4;
    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/updown_seq_ctrl.sv
// Sequencer driving an external up/down load counter from start to target; UDSEQ_LOOP_EN repeats runs.
// Latency: load 1 cycle after accept, one step per unpaused RUN cycle, done 1 cycle after target seen.
// Backpressure: cmd_ready only in IDLE; pause stalls the run in place, abort returns to IDLE.
module updown_seq_ctrl
    import updown_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             cmd_dir,
    input  logic             cmd_loop,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_count,
    output logic             cnt_load,
    output logic             cnt_control,
    output logic [WIDTH-1:0] cnt_data,
    output logic             busy,
    output logic             done,
`ifdef UDSEQ_LOOP_EN
    output logic [7:0]       pass_cnt,
`endif
    output logic             aborted
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] start_r;
    logic [WIDTH-1:0] target_r;
    logic             dir_r;
    logic             loop_r;
    logic             accept;
    logic             repeat_run;

    assign accept = cmd_valid && cmd_ready;

`ifdef UDSEQ_LOOP_EN
    assign repeat_run = loop_r;
`else
    logic unused_loop;
    assign unused_loop = loop_r;
    assign repeat_run  = 1'b0;
`endif

    // The counter has no enable: holding means reloading its own value.
    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        cnt_load    = 1'b1;
        cnt_control = DIR_DOWN;
        cnt_data    = cnt_count;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = LOAD;
            end
            LOAD: begin
                cnt_data  = start_r;
                state_nxt = RUN;
            end
            RUN: begin
                cnt_control = dir_r;
                if (cnt_count == target_r) state_nxt = DONE;
                else if (!pause)           cnt_load  = 1'b0;
            end
            DONE: begin
                state_nxt = repeat_run ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            cnt_load  = 1'b1;
            cnt_data  = cnt_count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            start_r  <= '0;
            target_r <= '0;
            dir_r    <= DIR_DOWN;
            loop_r   <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state   <= state_nxt;
            done    <= (state_nxt == DONE);
            aborted <= abort && (state != IDLE);
            busy    <= (state_nxt != IDLE);
            if (accept) begin
                start_r  <= cmd_start;
                target_r <= cmd_target;
                dir_r    <= cmd_dir;
                loop_r   <= cmd_loop;
            end
        end
    end

`ifdef UDSEQ_LOOP_EN
    // Counts in step with the done pulse, so it reads the pass number while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     pass_cnt <= 8'd0;
        else if (accept)             pass_cnt <= 8'd0;
        else if (state_nxt == DONE)  pass_cnt <= pass_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Bench for updown_seq_ctrl paired with a behavioural up/down load counter.
// Expected trajectories are derived from start/target/direction arithmetic and the pause/abort schedule.
module tb_updown_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_start;
    logic [3:0] cmd_target;
    logic       cmd_dir;
    logic       cmd_loop;
    logic       pause;
    logic       abort;
    logic [3:0] cnt_count = 4'd0;
    logic       cnt_load;
    logic       cnt_control;
    logic [3:0] cnt_data;
    logic       busy;
    logic       done;
    logic       aborted;
`ifdef UDSEQ_LOOP_EN
    logic [7:0] pass_cnt;
`endif

    int         n_chk = 0;
    int         n_err = 0;
    logic [3:0] model_cnt = 4'd0;

    always #5 clk = ~clk;

    // External counter: load, else count up/down with wrap.
    always @(posedge clk) begin
        if (cnt_load)         cnt_count <= cnt_data;
        else if (cnt_control) cnt_count <= cnt_count + 4'd1;
        else                  cnt_count <= cnt_count - 4'd1;
    end

    updown_seq_ctrl #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_start   (cmd_start),
        .cmd_target  (cmd_target),
        .cmd_dir     (cmd_dir),
        .cmd_loop    (cmd_loop),
        .pause       (pause),
        .abort       (abort),
        .cnt_count   (cnt_count),
        .cnt_load    (cnt_load),
        .cnt_control (cnt_control),
        .cnt_data    (cnt_data),
        .busy        (busy),
        .done        (done),
`ifdef UDSEQ_LOOP_EN
        .pass_cnt    (pass_cnt),
`endif
        .aborted     (aborted)
    );

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_target = '0;
        cmd_dir = 1'b0; cmd_loop = 1'b0; pause = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (cmd_ready !== 1'b1)   begin n_err++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        n_chk++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if (done !== 1'b0)        begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_chk++; if (aborted !== 1'b0)     begin n_err++; $display("FAIL reset_aborted got %b want 0", aborted); end
        n_chk++; if (cnt_load !== 1'b1)    begin n_err++; $display("FAIL reset_cnt_load got %b want 1", cnt_load); end
        n_chk++; if (cnt_control !== 1'b0) begin n_err++; $display("FAIL reset_cnt_control got %b want 0", cnt_control); end
        n_chk++; if (cnt_data !== 4'd0)    begin n_err++; $display("FAIL reset_cnt_data got %0d want 0", cnt_data); end
`ifdef UDSEQ_LOOP_EN
        n_chk++; if (pass_cnt !== 8'd0)    begin n_err++; $display("FAIL reset_pass_cnt got %0d want 0", pass_cnt); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (cnt_count !== 4'd0)   begin n_err++; $display("FAIL reset_hold got %0d want 0", cnt_count); end
    endtask

    // One command from IDLE, with an optional pause window (p_off: step index, p_len cycles),
    // optional abort at cycle ab_at after accept (0 = none), and optional cmd_valid while busy.
    task automatic run_cmd(input string nm, input logic [3:0] s, input logic [3:0] tg, input logic d,
                           input int p_off, input int p_len, input int ab_at, input bit busy_cmd);
        logic [3:0] steps;
        logic [3:0] q[$];
        logic [3:0] exp_c;
        int         t_done, t_stop, tt;
        bit         exp_busy, exp_done, exp_abt;
        steps = d ? (tg - s) : (s - tg);
        q = {};
        for (int i = 0; i <= int'(steps); i++) begin
            q.push_back(d ? s + 4'(i) : s - 4'(i));
            if (i == p_off)
                for (int j = 0; j < p_len; j++) q.push_back(q[$]);
        end
        t_done = 2 + q.size();
        t_stop = ((ab_at > 0) ? ab_at : t_done) + 2;

        cmd_valid = 1'b1; cmd_start = s; cmd_target = tg; cmd_dir = d; cmd_loop = 1'b0;
        #1;
        n_chk++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL %s accept_ready got %b want 1", nm, cmd_ready); end
        for (int t = 1; t <= t_stop; t++) begin
            @(posedge clk); #1;
            cmd_valid  = busy_cmd && (t <= 3);
            cmd_start  = ~s; cmd_target = ~tg; cmd_dir = ~d;
            pause = (p_len > 0) && ((t == 1) || (t >= 2 + p_off && t < 2 + p_off + p_len));
            abort = (t == ab_at);
            tt = ((ab_at > 0) && (t > ab_at)) ? ab_at : t;
            if (tt == 1)               exp_c = model_cnt;
            else if (tt - 2 < q.size()) exp_c = q[tt-2];
            else                       exp_c = tg;
            exp_busy = (ab_at > 0) ? (t <= ab_at) : (t <= t_done);
            exp_done = (t == t_done) && ((ab_at == 0) || (ab_at >= t_done));
            exp_abt  = (ab_at > 0) && (t == ab_at + 1);
            n_chk++; if (cnt_count !== exp_c)     begin n_err++; $display("FAIL %s count t=%0d got %0d want %0d", nm, t, cnt_count, exp_c); end
            n_chk++; if (busy !== exp_busy)       begin n_err++; $display("FAIL %s busy t=%0d got %b want %b", nm, t, busy, exp_busy); end
            n_chk++; if (done !== exp_done)       begin n_err++; $display("FAIL %s done t=%0d got %b want %b", nm, t, done, exp_done); end
            n_chk++; if (aborted !== exp_abt)     begin n_err++; $display("FAIL %s aborted t=%0d got %b want %b", nm, t, aborted, exp_abt); end
            n_chk++; if (cmd_ready !== !exp_busy) begin n_err++; $display("FAIL %s cmd_ready t=%0d got %b want %b", nm, t, cmd_ready, !exp_busy); end
            if (!exp_busy) begin
                n_chk++; if (cnt_load !== 1'b1 || cnt_control !== 1'b0)
                    begin n_err++; $display("FAIL %s idle_pins t=%0d got load=%b ctl=%b want load=1 ctl=0", nm, t, cnt_load, cnt_control); end
            end
        end
        model_cnt = exp_c;
        cmd_valid = 1'b0; pause = 1'b0; abort = 1'b0;
    endtask

    task automatic test_up();         run_cmd("up_1_5",      4'd1, 4'd5,  1'b1, 0, 0, 0, 1'b0); endtask
    task automatic test_down_wrap();  run_cmd("down_2_13",   4'd2, 4'd13, 1'b0, 0, 0, 0, 1'b0); endtask
    task automatic test_zero_steps(); run_cmd("zero_7_7",    4'd7, 4'd7,  1'b1, 0, 0, 0, 1'b0); endtask
    task automatic test_up_wrap();    run_cmd("up_14_1",     4'd14, 4'd1, 1'b1, 0, 0, 0, 1'b0); endtask
    task automatic test_pause();      run_cmd("pause_0_9",   4'd0, 4'd9,  1'b1, 4, 3, 0, 1'b0); endtask

    task automatic test_abort();
        run_cmd("abort_run",  4'd0, 4'd10, 1'b1, 0, 0, 5, 1'b1);
        run_cmd("abort_load", 4'd8, 4'd12, 1'b1, 0, 0, 1, 1'b0);
        run_cmd("abort_done", 4'd3, 4'd5,  1'b1, 0, 0, 5, 1'b0);
        // Abort while idle has no effect.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (aborted !== 1'b0 || busy !== 1'b0 || cnt_count !== model_cnt)
            begin n_err++; $display("FAIL abort_idle got abt=%b busy=%b cnt=%0d want 0 0 %0d", aborted, busy, cnt_count, model_cnt); end
    endtask

    task automatic test_random();
        logic [3:0] s, tg, steps;
        logic       d;
        int         p_len, p_off, ab_at;
        for (int n = 0; n < 25; n++) begin
            s = 4'($urandom); tg = 4'($urandom); d = 1'($urandom);
            steps = d ? (tg - s) : (s - tg);
            p_len = (steps > 1) ? int'($urandom_range(0, 3)) : 0;
            p_off = (steps > 1) ? int'($urandom_range(0, int'(steps) - 1)) : 0;
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3 + int'(steps) + p_len)) : 0;
            run_cmd("random", s, tg, d, p_off, p_len, ab_at, 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_run();
        cmd_valid = 1'b1; cmd_start = 4'd0; cmd_target = 4'd10; cmd_dir = 1'b1; cmd_loop = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0)
            begin n_err++; $display("FAIL rst_mid flags got busy=%b done=%b abt=%b want 0 0 0", busy, done, aborted); end
        n_chk++; if (cmd_ready !== 1'b1 || cnt_load !== 1'b1 || cnt_control !== 1'b0)
            begin n_err++; $display("FAIL rst_mid pins got rdy=%b load=%b ctl=%b want 1 1 0", cmd_ready, cnt_load, cnt_control); end
        n_chk++; if (cnt_data !== 4'd2)
            begin n_err++; $display("FAIL rst_mid cnt_data got %0d want 2", cnt_data); end
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        n_chk++; if (cnt_count !== 4'd2)
            begin n_err++; $display("FAIL rst_mid hold got %0d want 2", cnt_count); end
        model_cnt = 4'd2;
        cmd_loop  = 1'b0;
    endtask

`ifdef UDSEQ_LOOP_EN
    task automatic test_loop();
        logic [3:0] exp_c;
        int         r;
        cmd_valid = 1'b1; cmd_start = 4'd0; cmd_target = 4'd2; cmd_dir = 1'b1; cmd_loop = 1'b1;
        for (int t = 1; t <= 17; t++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            r = (t - 2) % 5;
            exp_c = (t == 1) ? model_cnt : ((r <= 2) ? 4'(r) : 4'd2);
            n_chk++; if (cnt_count !== exp_c) begin n_err++; $display("FAIL loop count t=%0d got %0d want %0d", t, cnt_count, exp_c); end
            n_chk++; if (done !== (t % 5 == 0)) begin n_err++; $display("FAIL loop done t=%0d got %b want %b", t, done, (t % 5 == 0)); end
            n_chk++; if (pass_cnt !== 8'(t / 5)) begin n_err++; $display("FAIL loop pass_cnt t=%0d got %0d want %0d", t, pass_cnt, t / 5); end
            n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL loop busy t=%0d got %b want 1", t, busy); end
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; cmd_loop = 1'b0;
        n_chk++; if (aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cnt_count !== 4'd0)
            begin n_err++; $display("FAIL loop_abort got abt=%b busy=%b done=%b cnt=%0d want 1 0 0 0", aborted, busy, done, cnt_count); end
        n_chk++; if (pass_cnt !== 8'd3) begin n_err++; $display("FAIL loop_abort pass_cnt got %0d want 3", pass_cnt); end
        model_cnt = 4'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_up();
        test_down_wrap();
        test_zero_steps();
        test_up_wrap();
        test_pause();
        test_abort();
        test_random();
`ifdef UDSEQ_LOOP_EN
        test_loop();
`endif
        test_reset_mid_run();
        test_up();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
